// File: rtl/etpu_array_sequencer.sv
// etpu_array_sequencer: runs one matrix-multiply tile through the NxN systolic array.
// Loads N weight rows, streams M activation rows, then writes M result rows once
// the 2N-cycle array latency has elapsed. Stall freezes sequencing and masks strobes.
// Optional macro ETPU_SEQ_PERF_EN enables the busy-cycle counter on perf_cycles.
module etpu_array_sequencer #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_r_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              arr_w_load,
    output logic [N-1:0]      arr_w_sel,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              arr_a_valid,
    output logic              arr_en,
    output logic              r_wr_en,
    output logic [ADDR_W-1:0] r_wr_addr,
    output logic [15:0]       perf_cycles
);

    localparam int unsigned DLY   = 2 * N;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cfg_rows_q;
    logic [ADDR_W-1:0]  cfg_a_base_q;
    logic [IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]   row_idx;
    logic               w_rd_en_q;
    logic [ADDR_W-1:0]  w_rd_addr_q;
    logic               arr_w_load_q;
    logic [N-1:0]       arr_w_sel_q;
    logic               a_rd_en_q;
    logic [ADDR_W-1:0]  a_rd_addr_q;
    logic [DLY-1:0]     dly;
    logic [ADDR_W-1:0]  r_wr_addr_q;
    logic               done_q;

    // Sequencer FSM with its counters, read strobes and the result delay line
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            cfg_rows_q   <= '0;
            cfg_a_base_q <= '0;
            w_idx        <= '0;
            row_idx      <= '0;
            w_rd_en_q    <= 1'b0;
            w_rd_addr_q  <= '0;
            arr_w_load_q <= 1'b0;
            arr_w_sel_q  <= '0;
            a_rd_en_q    <= 1'b0;
            a_rd_addr_q  <= '0;
            dly          <= '0;
            r_wr_addr_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                if (cfg_start) begin
                    cfg_rows_q   <= cfg_rows;
                    cfg_a_base_q <= cfg_a_base;
                    r_wr_addr_q  <= cfg_r_base;
                    if (cfg_rows == '0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state       <= S_LOAD_W;
                        w_rd_en_q   <= 1'b1;
                        w_rd_addr_q <= cfg_w_base;
                        w_idx       <= '0;
                    end
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end else if (!stall) begin
                // weight latch and select trail the weight read by one cycle
                arr_w_load_q <= w_rd_en_q;
                arr_w_sel_q  <= w_rd_en_q ? (N'(1) << w_idx) : '0;
                dly          <= {dly[DLY-2:0], a_rd_en_q};
                if (dly[DLY-1]) begin
                    r_wr_addr_q <= r_wr_addr_q + ADDR_W'(1);
                end
                if (state == S_LOAD_W) begin
                    if (w_idx == IDX_W'(N - 1)) begin
                        w_rd_en_q   <= 1'b0;
                        a_rd_en_q   <= 1'b1;
                        a_rd_addr_q <= cfg_a_base_q;
                        row_idx     <= '0;
                        state       <= S_STREAM;
                    end else begin
                        w_idx       <= w_idx + IDX_W'(1);
                        w_rd_addr_q <= w_rd_addr_q + ADDR_W'(1);
                    end
                end else if (state == S_STREAM) begin
                    if (row_idx == cfg_rows_q - CNT_W'(1)) begin
                        a_rd_en_q <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        row_idx     <= row_idx + CNT_W'(1);
                        a_rd_addr_q <= a_rd_addr_q + ADDR_W'(1);
                    end
                end else begin
                    // last write is leaving the delay line this edge
                    if (dly[DLY-2:0] == '0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign arr_en      = busy & ~stall;
    assign w_rd_en     = w_rd_en_q & ~stall;
    assign w_rd_addr   = w_rd_addr_q;
    assign arr_w_load  = arr_w_load_q & ~stall;
    assign arr_w_sel   = arr_w_sel_q;
    assign a_rd_en     = a_rd_en_q & ~stall;
    assign a_rd_addr   = a_rd_addr_q;
    assign arr_a_valid = dly[0] & ~stall;
    assign r_wr_en     = dly[DLY-1] & ~stall;
    assign r_wr_addr   = r_wr_addr_q;

`ifdef ETPU_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of busy cycles, cleared when a start is accepted
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            perf_q <= '0;
        end else if (state == S_IDLE && cfg_start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: doc/etpu_array_sequencer.md
Name: etpu_array_sequencer

Overview:
Controller that runs one matrix-multiply tile through the edu TPU's NxN systolic array inside the Caravel user area.
- Sequencing: on a start pulse it loads N weight rows from the weight buffer, then streams M activation rows from the activation buffer, then writes M result rows to the result buffer at the array's fixed skew latency.
- Control path: driven by the Wishbone-side register block and reports busy/done back to it.

Parameters:
N, 4, systolic array dimension (rows = columns = N)
ADDR_W, 8, buffer address width; all addresses wrap modulo 2^ADDR_W
CNT_W, 8, width of the activation row count

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous, active-high reset
cfg_start  in  1  start pulse; accepted only in IDLE
cfg_rows  in  CNT_W  activation row count M
cfg_w_base  in  ADDR_W  weight buffer base address
cfg_a_base  in  ADDR_W  activation buffer base address
cfg_r_base  in  ADDR_W  result buffer base address
stall  in  1  freeze request (bus contention on buffers)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
w_rd_en  out  1  weight buffer read strobe (read latency 1)
w_rd_addr  out  ADDR_W  weight read address
arr_w_load  out  1  array latches the weight row present on the buffer data bus
arr_w_sel  out  N  one-hot weight row select, valid with arr_w_load
a_rd_en  out  1  activation buffer read strobe (read latency 1)
a_rd_addr  out  ADDR_W  activation read address
arr_a_valid  out  1  activation row valid into the array
arr_en  out  1  array clock enable = busy & ~stall
r_wr_en  out  1  result buffer write strobe
r_wr_addr  out  ADDR_W  result write address
perf_cycles  out  16  see Optional Feature

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Delay line cleared.
  - Configuration registers cleared.
- Reset mid-operation: returns to IDLE on the next edge. No done pulse; no further strobes.
- cfg_start sampled at edge T while in IDLE latches all cfg_* inputs. cfg_start while busy is ignored; latched cfg is unchanged.
- States: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- M = 0: IDLE -> DONE directly. done is high at cycle T+1 and no strobes are issued.
- LOAD_W, cycles T+1..T+N:
  - w_rd_en = 1 and w_rd_addr = w_base + i for i = 0..N-1.
  - arr_w_load is w_rd_en delayed by one cycle.
  - arr_w_sel = 1<<i, also delayed by one cycle.
- STREAM, cycles T+N+1..T+N+M:
  - a_rd_en = 1 and a_rd_addr = a_base + j.
  - arr_a_valid is a_rd_en delayed by one cycle.
- Result timing: r_wr_en is a_rd_en delayed by exactly 2N enabled cycles (1 read latency + 2N-1 array skew). This is implemented as a 2N-deep delay line.
  - r_wr_addr = r_base + k, incremented per write.
  - Writes occur at cycles T+3N+1..T+3N+M.
- DRAIN: entered after the last a_rd_en. Exits to DONE when the delay line is empty and the last write has been issued.
- DONE: lasts one cycle. done = 1 and busy = 1; then IDLE.
- stall = 1:
  - Counters, state, delay lines and the arr_w_load/arr_a_valid pipeline registers all hold.
  - All strobes (w_rd_en, a_rd_en, arr_w_load, arr_a_valid, r_wr_en) are forced to 0 and arr_en = 0.
  - Sequencing resumes exactly where it stopped when stall falls. Each stall cycle adds one cycle to the total latency.
- stall in IDLE has no effect. A start accepted while stall = 1 still latches cfg; LOAD_W then holds until stall falls.
- Address arithmetic is unsigned modulo 2^ADDR_W. No overflow flag.
- Maximum M = 2^CNT_W - 1. The row counter must not wrap within an operation.

Optional Feature:
Macro ETPU_SEQ_PERF_EN.
- Defined:
  - perf_cycles counts wb_clk_i cycles with busy = 1, including stalled cycles.
  - Cleared on start acceptance; saturates at 0xFFFF.
  - Holds its value after done until the next start. Reset clears it.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- N=4, M=3, w_base=0x10, a_base=0x20, r_base=0x40, start at T:
  - w_rd_addr 0x10..0x13 at T+1..T+4; arr_w_sel 0001,0010,0100,1000 at T+2..T+5.
  - a_rd_addr 0x20..0x22 at T+5..T+7.
  - r_wr_addr 0x40..0x42 at T+13..T+15; done at T+16.
  - perf_cycles = 16 with the macro defined.
- Same config, stall high for 3 cycles at T+6: all strobes 0 during the stall; results at T+16..T+18; done at T+19. With the macro, perf_cycles = 19.
- a_base=0xFE, r_base=0xFF, M=4: a_rd_addr FE,FF,00,01; r_wr_addr FF,00,01,02.
- M=0: done at T+1 with busy=1 that cycle; zero read/write strobes.
- cfg_start pulsed at T+3 with different bases during an operation: ignored, and the original addresses complete. Then assert wb_rst_i at T+8: all outputs 0 the next cycle, no done pulse, and a new start afterwards runs normally.
